// File: rtl/alu_seq_if.sv
// Handshake bundle between the operand mux (master) and alu_seq (slave).
// Z/N/C/V flag signals exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdb;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;
`ifdef ALU_SEQ_FLAGS_EN
  logic             Z;
  logic             N;
  logic             C;
  logic             V;

  modport master (
    output in_valid, op, rda, rdb, flush, out_ready,
    input  in_ready, out_valid, result, busy, Z, N, C, V
  );
  modport slave (
    input  in_valid, op, rda, rdb, flush, out_ready,
    output in_ready, out_valid, result, busy, Z, N, C, V
  );
`else
  modport master (
    output in_valid, op, rda, rdb, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );
  modport slave (
    input  in_valid, op, rda, rdb, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
`endif
endinterface

// File: rtl/alu_seq.sv
// Handshaked execute ALU with iterative RV32M multiply/divide.
// Define ALU_SEQ_FLAGS_EN to add registered Z/N/C/V flag outputs.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL   = 5'd2,  OP_SRL  = 5'd3,
    OP_SRA  = 5'd4,  OP_AND  = 5'd5,  OP_OR    = 5'd6,  OP_XOR  = 5'd7,
    OP_PASB = 5'd8,  OP_SLT  = 5'd9,  OP_SLTU  = 5'd10
  } op_e;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [SHW-1:0]   count;
  logic [2:0]       md_op_q;
  logic             neg_q;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             is_md, is_div, a_signed, b_signed, a_neg, b_neg;
  logic             neg_next, div_zero, div_ovf, iter_op;
  logic [WIDTH-1:0] a_mag, b_mag, alu_res, quick_res, fix_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  assign bus.in_ready  = !bus.flush && (state == IDLE || (state == DONE && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == ITER) || (state == FIX);
  assign bus.result    = result_q;
  assign shamt         = bus.rdb[SHW-1:0];

  // Operand conditioning for the MUL/DIV group: magnitudes plus the sign to restore at FIX.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    is_md    = (bus.op[4:3] == 2'b10);
    is_div   = is_md && bus.op[2];
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (is_md) begin
      a_signed = is_div ? !bus.op[0] : (bus.op[1:0] != 2'b11);
      b_signed = is_div ? !bus.op[0] : !bus.op[1];
    end
    a_neg    = a_signed && bus.rda[WIDTH-1];
    b_neg    = b_signed && bus.rdb[WIDTH-1];
    a_mag    = a_neg ? -bus.rda : bus.rda;
    b_mag    = b_neg ? -bus.rdb : bus.rdb;
    neg_next = (is_div && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (bus.rdb == '0);
    div_ovf  = is_div && !bus.op[0] && (bus.rda == MOST_NEG) && (bus.rdb == '1);
    iter_op  = is_md && !div_zero && !div_ovf;
  end

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = bus.rda + bus.rdb;
      OP_SUB:  alu_res = bus.rda - bus.rdb;
      OP_SLL:  alu_res = bus.rda << shamt;
      OP_SRL:  alu_res = bus.rda >> shamt;
      OP_SRA:  alu_res = $signed(bus.rda) >>> shamt;
      OP_AND:  alu_res = bus.rda & bus.rdb;
      OP_OR:   alu_res = bus.rda | bus.rdb;
      OP_XOR:  alu_res = bus.rda ^ bus.rdb;
      OP_PASB: alu_res = bus.rdb;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.rda) < $signed(bus.rdb)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.rda < bus.rdb};
      default: alu_res = '0;
    endcase
    quick_res = alu_res;
    if (div_zero)     quick_res = bus.op[1] ? bus.rda : '1;
    else if (div_ovf) quick_res = bus.op[1] ? '0 : bus.rda;
  end

  // One iteration step: shift-add on {acc_hi,acc_lo}, or restoring divide with
  // acc_hi as partial remainder and acc_lo shifting dividend out / quotient in.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    prod_fix  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (!md_op_q[2])     fix_res = (md_op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    else if (md_op_q[1]) fix_res = neg_q ? -acc_hi : acc_hi;
    else                 fix_res = neg_q ? -acc_lo : acc_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      md_op_q  <= '0;
      neg_q    <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else if (accept) begin
      md_op_q <= bus.op[2:0];
      neg_q   <= neg_next;
      count   <= '0;
      if (iter_op) begin
        acc_hi <= '0;
        acc_lo <= a_mag;
        opb_q  <= b_mag;
        state  <= ITER;
      end else begin
        result_q <= quick_res;
        state    <= DONE;
      end
    end else begin
      case (state)
        ITER: begin
          if (!md_op_q[2]) begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end else if (!div_diff[WIDTH]) begin
            acc_hi <= div_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == SHW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          result_q <= fix_res;
          state    <= DONE;
        end
        DONE:    if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic           z_q, n_q, c_q, v_q;
  logic           c_next, v_next;
  logic [WIDTH:0] add_ext, sub_ext;

  // C/V come from the operand side of ADD/SUB; every other op clears them.
  always_comb begin
    add_ext = {1'b0, bus.rda} + {1'b0, bus.rdb};
    sub_ext = {1'b0, bus.rda} - {1'b0, bus.rdb};
    c_next  = 1'b0;
    v_next  = 1'b0;
    if (bus.op == OP_ADD) begin
      c_next = add_ext[WIDTH];
      v_next = (bus.rda[WIDTH-1] == bus.rdb[WIDTH-1]) && (add_ext[WIDTH-1] != bus.rda[WIDTH-1]);
    end else if (bus.op == OP_SUB) begin
      c_next = !sub_ext[WIDTH];
      v_next = (bus.rda[WIDTH-1] != bus.rdb[WIDTH-1]) && (sub_ext[WIDTH-1] != bus.rda[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {z_q, n_q, c_q, v_q} <= '0;
    end else if (!bus.flush) begin
      if (accept && !iter_op) begin
        z_q <= (quick_res == '0);
        n_q <= quick_res[WIDTH-1];
        c_q <= c_next;
        v_q <= v_next;
      end else if (state == FIX) begin
        z_q <= (fix_res == '0);
        n_q <= fix_res[WIDTH-1];
        c_q <= 1'b0;
        v_q <= 1'b0;
      end
    end
  end

  assign bus.Z = z_q;
  assign bus.N = n_q;
  assign bus.C = c_q;
  assign bus.V = v_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed test-plan steps, then random ops
// compared against an arithmetic reference model (latency, busy, result, flags).
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [4:0] sh;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    sh  = b[4:0];
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << sh;
      5'd3:  return a >> sh;
      5'd4:  return W'($signed(a) >>> sh);
      5'd5:  return a & b;
      5'd6:  return a | b;
      5'd7:  return a ^ b;
      5'd8:  return b;
      5'd9:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd10: return (ua < ub) ? 32'd1 : 32'd0;
      5'd16: begin p = 64'(sa * sb); return p[31:0]; end
      5'd17: begin p = 64'(sa * sb); return p[63:32]; end
      5'd18: begin p = 64'(sa * ub); return p[63:32]; end
      5'd19: begin p = 64'(a) * 64'(b); return p[63:32]; end
      5'd20: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : W'(sa / sb);
      5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: return (b == 0) ? a : ovf ? 32'd0 : W'(sa % sb);
      5'd23: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op < 5'd16 || op > 5'd23) return 1;
    if (op >= 5'd20 && b == 0) return 1;
    if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 2;
  endfunction

`ifdef ALU_SEQ_FLAGS_EN
  // {Z, N, C, V}
  function automatic logic [3:0] ref_flags(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    longint s;
    logic c, v;
    r = ref_result(op, a, b);
    c = 1'b0;
    v = 1'b0;
    if (op == 5'd0) begin
      s = longint'($signed(a)) + longint'($signed(b));
      c = (longint'(a) + longint'(b)) > 64'sh0_FFFF_FFFF;
      v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
    end else if (op == 5'd1) begin
      s = longint'($signed(a)) - longint'($signed(b));
      c = (a >= b);
      v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
    end
    return {r == 0, r[W-1], c, v};
  endfunction
`endif

  // Issue one op with out_ready=1; measure accept-to-out_valid latency and busy cycles.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n, lat, busy_cycles;
    n = 0;
    @(negedge clk);
    bus.op = op; bus.rda = a; bus.rdb = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check({tag, "_ready"}, W'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy === 1'b1) busy_cycles++;
    end while (bus.out_valid !== 1'b1 && lat < 100);
    check({tag, "_lat"}, W'(lat), W'(ref_latency(op, a, b)));
    check({tag, "_busy"}, W'(busy_cycles), W'(ref_latency(op, a, b) - 1));
    check({tag, "_res"}, bus.result, ref_result(op, a, b));
`ifdef ALU_SEQ_FLAGS_EN
    check({tag, "_flags"}, W'({bus.Z, bus.N, bus.C, bus.V}), W'(ref_flags(op, a, b)));
`endif
  endtask

  initial begin
    logic [4:0]   rop;
    logic [W-1:0] ra, rb;
    int           seen;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.rda = '0; bus.rdb = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready",  W'(bus.in_ready),  32'd1);
    check("rst_out_valid", W'(bus.out_valid), 32'd0);
    check("rst_result",    bus.result,        32'd0);
    check("rst_busy",      W'(bus.busy),      32'd0);
    rst = 1'b0;

    // Test-plan vectors, with the literal expectations checked alongside the model.
    run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_ovf_lit", bus.result, 32'h8000_0000);
`ifdef ALU_SEQ_FLAGS_EN
    check("add_ovf_vnc", W'({bus.V, bus.N, bus.C}), 32'b110);
`endif
    run_op("sra", 5'd4, 32'h8000_0000, 32'h0000_0024);
    check("sra_lit", bus.result, 32'hF800_0000);
    run_op("srl", 5'd3, 32'h8000_0000, 32'h0000_0024);
    check("srl_lit", bus.result, 32'h0800_0000);
    run_op("mulh", 5'd17, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mulh_lit", bus.result, 32'hFFFF_FFFF);
    run_op("mul", 5'd16, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mul_lit", bus.result, 32'hFFFF_FFFA);
    run_op("div", 5'd20, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_lit", bus.result, 32'hFFFF_FFFD);
    run_op("rem", 5'd22, 32'hFFFF_FFF9, 32'h0000_0002);
    check("rem_lit", bus.result, 32'hFFFF_FFFF);
    run_op("divu_z", 5'd21, 32'h0000_1234, 32'h0);
    check("divu_z_lit", bus.result, 32'hFFFF_FFFF);
    run_op("remu_z", 5'd23, 32'h0000_1234, 32'h0);
    check("remu_z_lit", bus.result, 32'h0000_1234);
    run_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lit", bus.result, 32'h8000_0000);
    run_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("slt", 5'd9, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("sltu", 5'd10, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("bad_op", 5'd27, 32'h1111_1111, 32'h2222_2222);

    // Back-to-back: second op accepted on the edge that retires the first.
    @(negedge clk);
    bus.op = 5'd0; bus.rda = 32'd5; bus.rdb = 32'd7; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.op = 5'd1;
    @(negedge clk);
    check("b2b_first_valid", W'(bus.out_valid), 32'd1);
    check("b2b_first_ready", W'(bus.in_ready),  32'd1);
    check("b2b_first_res",   bus.result,        32'd12);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_valid", W'(bus.out_valid), 32'd1);
    check("b2b_second_res",   bus.result,        32'hFFFF_FFFE);

    // Backpressure: result held and in_ready low while out_ready=0.
    @(negedge clk);
    bus.out_ready = 1'b0; bus.op = 5'd7; bus.rda = 32'h0000_F0F0; bus.rdb = 32'h0000_0FF0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", W'(bus.out_valid), 32'd1);
      check("bp_ready", W'(bus.in_ready),  32'd0);
      check("bp_res",   bus.result,        32'h0000_FF00);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_valid", W'(bus.out_valid), 32'd0);
    check("bp_release_ready", W'(bus.in_ready),  32'd1);

    // Flush during ITER kills the op.
    @(negedge clk);
    bus.op = 5'd20; bus.rda = 32'd100; bus.rdb = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("flush_busy_before", W'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy_after", W'(bus.busy),      32'd0);
    check("flush_valid",      W'(bus.out_valid), 32'd0);
    check("flush_ready",      W'(bus.in_ready),  32'd1);
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid !== 1'b0) seen++; end
    check("flush_no_result", W'(seen), 32'd0);

    // flush blocks a same-cycle request.
    @(negedge clk);
    bus.flush = 1'b1; bus.op = 5'd0; bus.in_valid = 1'b1;
    #1;
    check("flush_gate_ready", W'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_gate_valid", W'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-DIV.
    @(negedge clk);
    bus.op = 5'd20; bus.rda = 32'hFFFF_FFF9; bus.rdb = 32'd2; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("rstdiv_busy_before", W'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstdiv_busy",   W'(bus.busy),      32'd0);
    check("rstdiv_valid",  W'(bus.out_valid), 32'd0);
    check("rstdiv_ready",  W'(bus.in_ready),  32'd1);
    check("rstdiv_result", bus.result,        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset while a result is held in DONE.
    @(negedge clk);
    bus.out_ready = 1'b0; bus.op = 5'd6; bus.rda = 32'h00FF_0000; bus.rdb = 32'h0000_00FF; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rstdone_valid_before", W'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstdone_valid", W'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Random ops, biased toward divide-by-zero, overflow and small divisors.
    for (int k = 0; k < 60; k++) begin
      int r, sel;
      r   = $urandom_range(0, 99);
      rop = (r < 45) ? 5'($urandom_range(0, 10)) :
            (r < 90) ? 5'($urandom_range(16, 23)) : 5'($urandom_range(11, 31));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 16));
      run_op("rand", rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
